// File: rtl/fir_cfg_pkg.sv
// Shared constants and FSM state encoding for the FIR coefficient loader.
package fir_cfg_pkg;

  localparam int COEF_W   = 25;
  localparam int MAX_TAPS = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH
  } loader_state_t;

endpackage

// File: rtl/tap_ram.sv
// Tap buffer: single write port, registered read port, cleared on reset.
module tap_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 25,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is cleared on reset because an aborted load must leave
  // the buffer reading back zero; this rules out block-RAM mapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      // rd_data only moves on a read, so it doubles as the held cfg_din.
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Streams the tap buffer into the filter's coefficient shift chain, last tap first.
module fir_coef_loader
  import fir_cfg_pkg::*;
#(
  parameter int MAX_TAPS = fir_cfg_pkg::MAX_TAPS,
  parameter int COEF_W   = fir_cfg_pkg::COEF_W,
  parameter int AW       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fir_len,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              start,
  output logic [COEF_W-1:0] cfg_din,
  output logic              cfg_ce,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_t state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] len_m1_q;
  logic          bad_done_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic len_ok, addr_ok, start_ok, start_bad, wr_ok, wr_bad;

  assign len_ok    = (fir_len != 32'd0) && (fir_len <= 32'(MAX_TAPS));
  assign addr_ok   = 32'(wr_addr) < 32'(MAX_TAPS);
  assign start_ok  = (state_q == IDLE) && start && len_ok;
  assign start_bad = (state_q == IDLE) && start && !len_ok;
  assign wr_ok     = wr_en && !busy && addr_ok;
  assign wr_bad    = wr_en && (busy || !addr_ok);

  assign busy   = (state_q == LOAD) || (state_q == SHIFT);
  assign cfg_ce = (state_q == SHIFT);
  assign done   = (state_q == FINISH) || bad_done_q;

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = idx_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        rd_en   = 1'b1;
        rd_addr = len_m1_q;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (idx_q != '0) begin
          rd_en   = 1'b1;
          rd_addr = idx_q - AW'(1);
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_m1_q   <= '0;
      bad_done_q <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      bad_done_q <= start_bad;
      if (start_ok) len_m1_q <= AW'(fir_len - 32'd1);
      if (state_q == LOAD) idx_q <= len_m1_q;
      else if (state_q == SHIFT && idx_q != '0) idx_q <= idx_q - AW'(1);
      // A bad write in the same cycle as an accepted start still flags.
      if (start_bad || wr_bad) err <= 1'b1;
      else if (start_ok)       err <= 1'b0;
    end
  end

  tap_ram #(
    .DEPTH(MAX_TAPS),
    .W    (COEF_W),
    .AW   (AW)
  ) u_tap_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(cfg_din)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench: stimulus pushes expected cfg_din beats and done cycles, a monitor pops them.
module tb_fir_coef_loader;

  localparam int COEF_W = 25;
  localparam int AW     = 6;

  typedef struct {
    int               cyc;
    logic [COEF_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       fir_len = '0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [COEF_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [COEF_W-1:0] cfg_din;
  logic              cfg_ce, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t exp_q[$];
  int    done_q[$];
  logic [COEF_W-1:0] chain [1:5];

  fir_coef_loader #(.MAX_TAPS(64), .COEF_W(COEF_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .fir_len(fir_len), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .cfg_din(cfg_din),
    .cfg_ce(cfg_ce), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (cfg_ce === 1'b1) begin
      for (int k = 5; k > 1; k--) chain[k] = chain[k-1];
      chain[1] = cfg_din;
      if (exp_q.size() == 0) begin
        check("unexpected_cfg_ce", 32'(cfg_ce), 32'd0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("cfg_ce_cycle", cyc, b.cyc);
        check("cfg_din", 32'(cfg_din), 32'(b.data));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write(input int a, input logic [COEF_W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues start in the current cycle T; expected beats are entries n-1..0.
  task automatic start_load(input int len, input logic [COEF_W-1:0] vals [$], output int t);
    t = cyc;
    fir_len = 32'(len);
    start = 1'b1;
    if (len >= 1 && len <= 64) begin
      for (int j = 0; j < len; j++) exp_q.push_back('{t + 2 + j, vals[len-1-j]});
      done_q.push_back(t + 2 + len);
    end else begin
      done_q.push_back(t + 1);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  initial begin
    logic [COEF_W-1:0] v [$];
    int t;

    for (int k = 1; k <= 5; k++) chain[k] = '0;
    tick(2);
    check("rst_cfg_ce", 32'(cfg_ce), 0);
    check("rst_cfg_din", 32'(cfg_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b1;
    tick(2);

    // 1: five-tap load of 1..5
    v = '{25'd1, 25'd2, 25'd3, 25'd4, 25'd5};
    for (int i = 0; i < 5; i++) write(i, v[i]);
    start_load(5, v, t);
    for (int j = 1; j <= 7; j++) begin
      check("s1_busy", 32'(busy), (j <= 6) ? 32'd1 : 32'd0);
      tick();
    end
    check("s1_err", 32'(err), 0);
    check_drained("s1");
    for (int k = 1; k <= 5; k++) check("s1_chain", 32'(chain[k]), 32'(k));

    // 2: illegal lengths 0 and 65
    start_load(0, v, t);
    check("s2_err_len0", 32'(err), 1);
    check("s2_busy_len0", 32'(busy), 0);
    tick(3);
    start_load(65, v, t);
    check("s2_err_len65", 32'(err), 1);
    check("s2_busy_len65", 32'(busy), 0);
    tick(3);
    check_drained("s2");

    // 3: write and start during a load are dropped
    start_load(5, v, t);
    check("s3_err_cleared", 32'(err), 0);
    tick(2);
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = 25'h1FFFFFF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("s3_err_set", 32'(err), 1);
    tick(6);
    check_drained("s3");

    // 5: reset at T+4 aborts; buffer reads back as zero afterwards
    start_load(5, v, t);
    tick(3);
    reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    check("s5_cfg_ce", 32'(cfg_ce), 0);
    check("s5_cfg_din", 32'(cfg_din), 0);
    check("s5_busy", 32'(busy), 0);
    check("s5_done", 32'(done), 0);
    tick(3);
    reset = 1'b1;
    tick(2);
    v = '{25'd0, 25'd0, 25'd0};
    start_load(3, v, t);
    tick(6);
    check_drained("s5");

    // 6: write and start in the same idle cycle
    v = '{25'h0ABCDE};
    wr_en = 1'b1; wr_addr = '0; wr_data = 25'h0ABCDE;
    start_load(1, v, t);
    wr_en = 1'b0;
    tick(4);
    check("s6_err", 32'(err), 0);
    check_drained("s6");

    // 4: full-depth load, entry i = i + 100
    v.delete();
    for (int i = 0; i < 64; i++) begin
      v.push_back(COEF_W'(i + 100));
      write(i, COEF_W'(i + 100));
    end
    start_load(64, v, t);
    tick(68);
    check("s4_busy", 32'(busy), 0);
    check_drained("s4");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
